uop_bundler: RTL

UOP_BUNDLER -- requirements
Module: uop_bundler

---
 rtl/uop_bundler_pkg.sv | 9 +
 rtl/uop_fifo.sv | 42 ++++
 rtl/uop_bundler.sv | 70 +++++++
 3 files changed

// File: rtl/uop_bundler_pkg.sv
// uop_bundler_pkg: shared micro-op constants and bundler state encoding
package uop_bundler_pkg;
  localparam int UOP_W = 24;
  localparam int PR_ADDR_W = 6;
  localparam int RENAMED_OP_SZ = 4 + 3 * PR_ADDR_W;
  localparam logic [UOP_W-1:0] UOP_NOP = {4'hF, 20'h0};
  typedef logic [UOP_W-1:0] uop_t;
  typedef enum logic [1:0] {EMPTY, FILL, OFFER} state_t;
endpackage

// File: rtl/uop_fifo.sv
// uop_fifo: circular micro-op buffer, one write per cycle, WIDTH-wide read-out from head
module uop_fifo
  import uop_bundler_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int NW = $clog2(WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_en,
  input  uop_t                   wr_data,
  input  logic [NW-1:0]          rd_n,
  output logic [WIDTH*UOP_W-1:0] rd_data,
  output logic [CW-1:0]          count
);
  uop_t mem [DEPTH];
  logic [AW-1:0] head, tail;
  // storage write at tail; rst and clr discard the write
  always_ff @(posedge clk)
    if (wr_en && !rst && !clr) mem[tail] <= wr_data;
  // pointers and occupancy; clr empties the queue by snapping head onto tail
  always_ff @(posedge clk)
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (clr) begin
      head <= tail;
      count <= '0;
    end else begin
      if (wr_en) tail <= tail + AW'(1);
      head <= head + AW'(rd_n);
      count <= count + CW'(wr_en) - CW'(rd_n);
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_rd
    assign rd_data[(WIDTH-1-i)*UOP_W +: UOP_W] = mem[head + AW'(i)];
  end
endmodule

// File: rtl/uop_bundler.sv
// uop_bundler: queues micro-ops and offers them as WIDTH-lane bundles (UOP_BUNDLER_TIMEOUT_EN: hold partial bundles until idle timeout)
module uop_bundler
  import uop_bundler_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [UOP_W-1:0]       in_uop,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH*UOP_W-1:0] out_uops,
  output logic [WIDTH-1:0]       out_lane_valid,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = $clog2(WIDTH) + 1;
  state_t state;
  logic [NW-1:0] n_q, pop_n;
  logic [CW-1:0] count, next_cnt;
  logic [WIDTH*UOP_W-1:0] rd_data;
  logic push, hs, fire;
  assign in_ready = count != CW'(DEPTH);
  assign out_valid = state == OFFER;
  assign push = in_valid && in_ready && !flush;
  assign hs = out_valid && out_ready && !flush;
  assign pop_n = hs ? n_q : '0;
  assign next_cnt = count + CW'(push) - CW'(pop_n);
`ifdef UOP_BUNDLER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] timer;
  assign fire = state == FILL && timer == TW'(TIMEOUT - 1);
  // idle timer: counts FILL cycles with no push, restarts on any queue activity
  always_ff @(posedge clk)
    timer <= (rst || flush || push || hs || state != FILL || fire) ? '0 : timer + TW'(1);
`else
  assign fire = state == FILL;
`endif
  uop_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .wr_en(push),
    .wr_data(in_uop),
    .rd_n(pop_n),
    .rd_data(rd_data),
    .count(count)
  );
  // bundle FSM; n_q latches the offered lane count so later pushes cannot grow the bundle
  always_ff @(posedge clk)
    if (rst || flush) begin
      state <= EMPTY;
      n_q <= '0;
    end else if (state == OFFER && !hs) begin
      state <= OFFER;
    end else if (next_cnt >= CW'(WIDTH) || fire) begin
      state <= OFFER;
      n_q <= next_cnt >= CW'(WIDTH) ? NW'(WIDTH) : NW'(next_cnt);
    end else begin
      state <= next_cnt != '0 ? FILL : EMPTY;
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign out_lane_valid[WIDTH-1-i] = out_valid && n_q > NW'(i);
    assign out_uops[(WIDTH-1-i)*UOP_W +: UOP_W] = out_lane_valid[WIDTH-1-i] ? rd_data[(WIDTH-1-i)*UOP_W +: UOP_W] : UOP_NOP;
  end
endmodule
